// File: rtl/noc_vc_input_port_if.sv
// Link bundle for the VC input port: upstream flit/credit-return side plus downstream flit/credit side.
// The slave modport is the port itself; master is the neighbouring router or a test driver.
interface noc_vc_input_port_if #(
  parameter int DATA_W = 16,
  parameter int NUM_VC = 2
);
  localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  logic              valid_i;
  logic [VC_W-1:0]   vc_i;
  logic [DATA_W-1:0] data_i;
  logic [NUM_VC-1:0] credit_i;
  logic              enable_o;
  logic [VC_W-1:0]   vc_o;
  logic [DATA_W-1:0] data_o;
  logic [NUM_VC-1:0] credit_o;
  logic              err_o;

  modport slave (
    input  valid_i, vc_i, data_i, credit_i,
    output enable_o, vc_o, data_o, credit_o, err_o
  );

  modport master (
    output valid_i, vc_i, data_i, credit_i,
    input  enable_o, vc_o, data_o, credit_o, err_o
  );
endinterface

// File: rtl/noc_vc_input_port.sv
// Credit-based NoC input port: per-VC FIFOs, round-robin VC arbitration, per-VC downstream credit counters.
// Optional protocol-error detection on err_o is enabled by defining NOC_ERR_CHECK_EN.
module noc_vc_input_port #(
  parameter int DATA_W     = 16,
  parameter int NUM_VC     = 2,
  parameter int DEPTH      = 4,
  parameter int DN_CREDITS = 4
) (
  input logic             clk,
  input logic             rst,
  noc_vc_input_port_if.slave bus
);
  localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int CR_W  = $clog2(DN_CREDITS + 1);

  logic [DATA_W-1:0] mem_r    [NUM_VC][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr_r [NUM_VC];
  logic [CNT_W-1:0]  occ_r    [NUM_VC];
  logic [CR_W-1:0]   cnt_r    [NUM_VC];
  logic [VC_W-1:0]   rr_ptr_r;
  logic              enable_r;
  logic [VC_W-1:0]   vc_r;
  logic [DATA_W-1:0] data_r;
  logic [NUM_VC-1:0] credit_r;

  logic [NUM_VC-1:0] elig_s;
  logic [NUM_VC-1:0] full_s;
  logic [NUM_VC-1:0] sat_s;
  logic              grant_s;
  logic [VC_W-1:0]   gnt_vc_s;
  logic              vc_ok_s;
  logic              push_ok_s;

  // First eligible VC at or after ptr, wrapping; MSB of the result flags a grant.
  function automatic logic [VC_W:0] rr_pick(input logic [NUM_VC-1:0] elig, input logic [VC_W-1:0] ptr);
    logic            found;
    logic [VC_W-1:0] pick;
    int              idx;
    found = 1'b0;
    pick  = {VC_W{1'b0}};
    for (int i = 0; i < NUM_VC; i++) begin
      idx = (int'(ptr) + i) % NUM_VC;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = VC_W'(idx);
      end else begin
        found = found;
      end
    end
    return {found, pick};
  endfunction

  // Per-VC status flags derived from registered state.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      elig_s[v] = (occ_r[v] != {CNT_W{1'b0}}) && (cnt_r[v] != {CR_W{1'b0}});
      full_s[v] = (occ_r[v] == CNT_W'(DEPTH));
      sat_s[v]  = (cnt_r[v] == CR_W'(DN_CREDITS));
    end
  end

  // Arbitration and enqueue acceptance; a full FIFO still accepts when it pops the same cycle.
  always_comb begin
    {grant_s, gnt_vc_s} = rr_pick(elig_s, rr_ptr_r);
    vc_ok_s             = (32'(bus.vc_i) < NUM_VC);
    if (bus.valid_i && vc_ok_s) begin
      push_ok_s = !full_s[bus.vc_i] || (grant_s && (gnt_vc_s == bus.vc_i));
    end else begin
      push_ok_s = 1'b0;
    end
  end

  // FIFO storage, pointers, occupancy and credit counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        for (int d = 0; d < DEPTH; d++) begin
          mem_r[v][d] <= {DATA_W{1'b0}};
        end
        wr_ptr_r[v] <= {PTR_W{1'b0}};
        rd_ptr_r[v] <= {PTR_W{1'b0}};
        occ_r[v]    <= {CNT_W{1'b0}};
        cnt_r[v]    <= CR_W'(DN_CREDITS);
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (push_ok_s && (32'(bus.vc_i) == v)) begin
          mem_r[v][wr_ptr_r[v]] <= bus.data_i;
          wr_ptr_r[v]           <= wr_ptr_r[v] + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        if (grant_s && (32'(gnt_vc_s) == v)) begin
          rd_ptr_r[v] <= rd_ptr_r[v] + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        occ_r[v] <= occ_r[v] + CNT_W'(push_ok_s && (32'(bus.vc_i) == v))
                             - CNT_W'(grant_s && (32'(gnt_vc_s) == v));
        // A grant and a returning credit on the same VC cancel out.
        if (grant_s && (32'(gnt_vc_s) == v) && !bus.credit_i[v]) begin
          cnt_r[v] <= cnt_r[v] - {{(CR_W-1){1'b0}}, 1'b1};
        end else if (bus.credit_i[v] && !(grant_s && (32'(gnt_vc_s) == v)) && !sat_s[v]) begin
          cnt_r[v] <= cnt_r[v] + {{(CR_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_r[v] <= cnt_r[v];
        end
      end
    end
  end

  // Registered downstream flit, upstream credit pulse and RR pointer advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_r <= 1'b0;
      vc_r     <= {VC_W{1'b0}};
      data_r   <= {DATA_W{1'b0}};
      credit_r <= {NUM_VC{1'b0}};
      rr_ptr_r <= {VC_W{1'b0}};
    end else if (grant_s) begin
      enable_r <= 1'b1;
      vc_r     <= gnt_vc_s;
      data_r   <= mem_r[gnt_vc_s][rd_ptr_r[gnt_vc_s]];
      credit_r <= NUM_VC'(1) << gnt_vc_s;
      rr_ptr_r <= VC_W'((int'(gnt_vc_s) + 1) % NUM_VC);
    end else begin
      enable_r <= 1'b0;
      credit_r <= {NUM_VC{1'b0}};
    end
  end

  assign bus.enable_o = enable_r;
  assign bus.vc_o     = vc_r;
  assign bus.data_o   = data_r;
  assign bus.credit_o = credit_r;

`ifdef NOC_ERR_CHECK_EN
  logic err_r;
  logic err_set_s;

  // Dropped push (full or bad VC) or a credit arriving at a saturated counter.
  always_comb begin
    if (bus.valid_i && !push_ok_s) begin
      err_set_s = 1'b1;
    end else begin
      err_set_s = |(bus.credit_i & sat_s);
    end
  end

  // Sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | err_set_s;
    end
  end

  assign bus.err_o = err_r;
`else
  assign bus.err_o = 1'b0;
`endif
endmodule
